// File: rtl/pixel_class_pkg.sv
// rtl/pixel_class_pkg.sv - shared hue constants, HSV types and wrap-aware hue range test
package pixel_class_pkg;

  localparam int HUE_W   = 9;
  localparam int HUE_DEG = 360;

  // which channel supplied the maximum; ties resolve R > G > B
  typedef enum logic [1:0] {
    MAX_R = 2'd0,
    MAX_G = 2'd1,
    MAX_B = 2'd2
  } max_sel_e;

  // hue before sector offset and sign are applied
  typedef struct packed {
    max_sel_e   sel;
    logic       neg;
    logic [7:0] q;
  } hue_raw_t;

  typedef struct packed {
    logic [HUE_W-1:0] hue;
    logic [7:0]       sat;
    logic [7:0]       val;
  } hsv_t;

  // lo > hi describes a range that wraps through 0 degrees
  function automatic logic hue_in_range(input logic [HUE_W-1:0] hue,
                                        input logic [HUE_W-1:0] lo,
                                        input logic [HUE_W-1:0] hi);
    if (lo <= hi) return (hue >= lo) && (hue <= hi);
    return (hue >= lo) || (hue <= hi);
  endfunction

endpackage

// File: rtl/rgb_to_hsv.sv
// rtl/rgb_to_hsv.sv - input register, max/min select (S1) and hue/saturation divide (S2)
module rgb_to_hsv
  import pixel_class_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [23:0] pixel,
  input  logic        sop,
  input  logic        eop,
  output logic        hsv_valid,
  output logic [23:0] hsv_pixel,
  output logic        hsv_sop,
  output logic        hsv_eop,
  output hue_raw_t    hue_raw,
  output logic [7:0]  sat,
  output logic [7:0]  val
);

  logic        s0_valid, s0_sop, s0_eop;
  logic [23:0] s0_pixel;
  logic        s1_valid, s1_sop, s1_eop, s1_neg;
  logic [23:0] s1_pixel;
  logic [7:0]  s1_max, s1_delta, s1_diff;
  max_sel_e    s1_sel;

  logic [7:0]  r, g, b;
  logic [7:0]  c_max, c_min, c_diff;
  logic        c_neg;
  max_sel_e    c_sel;

  assign r = s0_pixel[23:16];
  assign g = s0_pixel[15:8];
  assign b = s0_pixel[7:0];

  // stage valids advance together on the global enable; reset drops all in-flight beats
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      hsv_valid <= 1'b0;
    end else if (en) begin
      s0_valid  <= in_valid;
      s1_valid  <= s0_valid;
      hsv_valid <= s1_valid;
    end
  end

  // S1: pick the max channel, the channel difference feeding the hue numerator and its sign
  always_comb begin
    c_sel  = MAX_R;
    c_max  = r;
    c_diff = '0;
    c_neg  = 1'b0;
    if (r >= g && r >= b) begin
      c_sel  = MAX_R;
      c_max  = r;
      c_diff = (g >= b) ? g - b : b - g;
      c_neg  = g < b;
    end else if (g >= b) begin
      c_sel  = MAX_G;
      c_max  = g;
      c_diff = (b >= r) ? b - r : r - b;
      c_neg  = b < r;
    end else begin
      c_sel  = MAX_B;
      c_max  = b;
      c_diff = (r >= g) ? r - g : g - r;
      c_neg  = r < g;
    end
    c_min = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
  end

  // datapath registers: input capture, S1 results, S2 divisions
  always_ff @(posedge clk) begin
    if (en) begin
      s0_pixel    <= pixel;
      s0_sop      <= sop;
      s0_eop      <= eop;
      s1_pixel    <= s0_pixel;
      s1_sop      <= s0_sop;
      s1_eop      <= s0_eop;
      s1_max      <= c_max;
      s1_delta    <= c_max - c_min;
      s1_diff     <= c_diff;
      s1_sel      <= c_sel;
      s1_neg      <= c_neg;
      hsv_pixel   <= s1_pixel;
      hsv_sop     <= s1_sop;
      hsv_eop     <= s1_eop;
      hue_raw.sel <= s1_sel;
      hue_raw.neg <= s1_neg;
      hue_raw.q   <= (s1_delta == 8'd0) ? 8'd0
                   : 8'((16'(s1_diff) * 16'd60) / 16'(s1_delta));
      sat         <= (s1_max == 8'd0) ? 8'd0
                   : 8'((16'(s1_delta) * 16'd255) / 16'(s1_max));
      val         <= s1_max;
    end
  end

endmodule

// File: rtl/pixel_classifier_pipe.sv
// rtl/pixel_classifier_pipe.sv - streaming RGB hue classifier; PIXEL_CLASS_COUNT_EN adds per-frame histograms
module pixel_classifier_pipe #(
  parameter int NUM_CLASSES = 6,
  parameter int HUE_W       = 9,
  parameter int COUNT_W     = 20,
  parameter int CLS_W       = $clog2(NUM_CLASSES + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2*NUM_CLASSES*HUE_W-1:0]     classifier_config,
  input  logic [7:0]                         sat_min,
  input  logic [7:0]                         val_min,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [23:0]                        pixel_in,
  input  logic                               in_sop,
  input  logic                               in_eop,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [23:0]                        pixel_out,
  output logic [CLS_W-1:0]                   pixel_classification,
  output logic                               out_sop,
  output logic                               out_eop,
  output logic [(NUM_CLASSES+1)*COUNT_W-1:0] class_count,
  output logic                               count_valid
);
  import pixel_class_pkg::*;

  localparam int CFG_W = 2 * NUM_CLASSES * HUE_W;

  logic             en;
  logic [CFG_W-1:0] in_cfg, cmp_cfg, cfg_eff;
  logic [7:0]       in_sat_min, in_val_min, cmp_sat_min, cmp_val_min, sat_eff, val_eff;

  logic             s2_valid, s2_sop, s2_eop;
  logic [23:0]      s2_pixel;
  hue_raw_t         s2_raw;
  logic [7:0]       s2_sat, s2_val;

  logic [HUE_W-1:0]       q_ext, hue_fix;
  hsv_t                   s3_hsv;
  logic [NUM_CLASSES-1:0] match;
  logic                   gate;

  logic                   s3_valid, s3_sop, s3_eop, s3_gate;
  logic [23:0]            s3_pixel;
  logic [NUM_CLASSES-1:0] s3_match;
  logic [CLS_W-1:0]       code;

  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // input shadow captures the config presented with each accepted start-of-frame beat
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cfg     <= '0;
      in_sat_min <= '0;
      in_val_min <= '0;
    end else if (in_valid && en && in_sop) begin
      in_cfg     <= classifier_config;
      in_sat_min <= sat_min;
      in_val_min <= val_min;
    end
  end

  rgb_to_hsv u_rgb_to_hsv (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .pixel     (pixel_in),
    .sop       (in_sop),
    .eop       (in_eop),
    .hsv_valid (s2_valid),
    .hsv_pixel (s2_pixel),
    .hsv_sop   (s2_sop),
    .hsv_eop   (s2_eop),
    .hue_raw   (s2_raw),
    .sat       (s2_sat),
    .val       (s2_val)
  );

  // a sop beat entering the compare stage already sees its own frame's config
  assign cfg_eff = (s2_valid && s2_sop) ? in_cfg     : cmp_cfg;
  assign sat_eff = (s2_valid && s2_sop) ? in_sat_min : cmp_sat_min;
  assign val_eff = (s2_valid && s2_sop) ? in_val_min : cmp_val_min;

  // compare shadow switches frames only when the sop beat moves into S3
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_cfg     <= '0;
      cmp_sat_min <= '0;
      cmp_val_min <= '0;
    end else if (en && s2_valid && s2_sop) begin
      cmp_cfg     <= in_cfg;
      cmp_sat_min <= in_sat_min;
      cmp_val_min <= in_val_min;
    end
  end

  assign q_ext = HUE_W'(s2_raw.q);

  // S3 hue fix-up: apply the sector offset and sign; red sector wraps negatives below 360
  always_comb begin
    hue_fix = q_ext;
    case (s2_raw.sel)
      MAX_G:   hue_fix = s2_raw.neg ? HUE_W'(120) - q_ext : HUE_W'(120) + q_ext;
      MAX_B:   hue_fix = s2_raw.neg ? HUE_W'(240) - q_ext : HUE_W'(240) + q_ext;
      default: hue_fix = (s2_raw.neg && q_ext != '0) ? HUE_W'(HUE_DEG) - q_ext : q_ext;
    endcase
  end

  assign s3_hsv = '{hue: hue_fix, sat: s2_sat, val: s2_val};
  assign gate   = (s3_hsv.sat >= sat_eff) && (s3_hsv.val >= val_eff);

  // S3 range compares against every configured class
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      match[i] = hue_in_range(s3_hsv.hue, cfg_eff[2*i*HUE_W +: HUE_W],
                              cfg_eff[(2*i+1)*HUE_W +: HUE_W]);
    end
  end

  // S3 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
    end else if (en) begin
      s3_valid <= s2_valid;
    end
  end

  // S3 data register
  always_ff @(posedge clk) begin
    if (en) begin
      s3_pixel <= s2_pixel;
      s3_sop   <= s2_sop;
      s3_eop   <= s2_eop;
      s3_match <= match;
      s3_gate  <= gate;
    end
  end

  // S4 priority encode: lowest matching class wins, the S/V floors veto everything
  always_comb begin
    code = '0;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (s3_match[i]) code = CLS_W'(i + 1);
    end
    if (!s3_gate) code = '0;
  end

  // output register holds steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid            <= 1'b0;
      pixel_out            <= '0;
      pixel_classification <= '0;
      out_sop              <= 1'b0;
      out_eop              <= 1'b0;
    end else if (en) begin
      out_valid            <= s3_valid;
      pixel_out            <= s3_pixel;
      pixel_classification <= code;
      out_sop              <= s3_sop;
      out_eop              <= s3_eop;
    end
  end

`ifdef PIXEL_CLASS_COUNT_EN
  logic [COUNT_W-1:0] live   [NUM_CLASSES+1];
  logic [COUNT_W-1:0] bumped [NUM_CLASSES+1];
  logic               handshake;

  assign handshake = out_valid && out_ready;

  // live counts with the current output beat folded in, saturating at all-ones
  always_comb begin
    for (int k = 0; k <= NUM_CLASSES; k++) begin
      bumped[k] = live[k];
      if (pixel_classification == CLS_W'(k) && live[k] != '1) bumped[k] = live[k] + COUNT_W'(1);
    end
  end

  // count each delivered beat; an eop delivery publishes the frame totals and restarts
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= NUM_CLASSES; k++) live[k] <= '0;
      class_count <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= handshake && out_eop;
      if (handshake) begin
        for (int k = 0; k <= NUM_CLASSES; k++) begin
          if (out_eop) begin
            class_count[k*COUNT_W +: COUNT_W] <= bumped[k];
            live[k]                           <= '0;
          end else begin
            live[k] <= bumped[k];
          end
        end
      end
    end
  end
`else
  assign class_count = '0;
  assign count_valid = 1'b0;
`endif

endmodule
